// File: rtl/ultrasonic_echo_responder_pkg.sv
// Shared types, default timing constants and small arithmetic helpers
// for the ultrasonic echo responder (HC-SR04 style target emulator).
package ultrasonic_echo_responder_pkg;

  localparam int unsigned CLK_HZ               = 32'd100_000_000;
  localparam int unsigned MIN_TRIG_CYC_DEFAULT = 32'd1_000;      // 10 us
  localparam int unsigned BURST_CYC_DEFAULT    = 32'd20_000;     // 200 us
  localparam int unsigned MAX_ECHO_CYC_DEFAULT = 32'd3_800_000;  // 38 ms
  localparam int unsigned HOLDOFF_CYC_DEFAULT  = 32'd1_000_000;  // 10 ms

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_BURST   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // True when a counter that started at 0 on state entry has covered
  // 'lim' cycles including the current one; evaluated in 33 bits so the
  // +1 can never wrap.
  function automatic logic count_reached(input logic [31:0] cnt,
                                         input logic [31:0] lim);
    count_reached = (({1'b0, cnt} + 33'd1) >= {1'b0, lim});
  endfunction

  // Commanded echo width: zero becomes one cycle, large values clip.
  function automatic logic [31:0] clamp_len(input logic [31:0] req,
                                            input logic [31:0] max_len);
    if (req == 32'd0) begin
      clamp_len = 32'd1;
    end else if (req > max_len) begin
      clamp_len = max_len;
    end else begin
      clamp_len = req;
    end
  endfunction

endpackage

// File: rtl/ultrasonic_echo_responder_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reused for the
// trigger here and for an initiator's echo input elsewhere.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Shift the asynchronous level through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// Ultrasonic echo responder: qualifies a trigger pulse, waits out the
// emulated transducer burst, drives an echo pulse of the commanded width,
// then enforces a dead time before the next ranging request.
module ultrasonic_echo_responder
  import ultrasonic_echo_responder_pkg::*;
#(
  parameter int unsigned MIN_TRIG_CYC = MIN_TRIG_CYC_DEFAULT,
  parameter int unsigned BURST_CYC    = BURST_CYC_DEFAULT,
  parameter int unsigned MAX_ECHO_CYC = MAX_ECHO_CYC_DEFAULT,
  parameter int unsigned HOLDOFF_CYC  = HOLDOFF_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [31:0] echo_len,
  output logic        echo,
  output logic        busy,
  output logic        short_trig,
  output logic        echo_done
);

  logic        trig_s;
  logic        trig_rise_s;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic        trig_prev_q, trig_prev_d;
  logic        armed_q, armed_d;
  logic [1:0]  flush_q, flush_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        short_q, short_d;
  logic        done_q, done_d;

  sync_2ff u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trigger),
    .q     (trig_s)
  );

  // Next-state logic: edge qualification, phase counting and output decode.
  always_comb begin
    // The synchronizer output is only meaningful two edges after reset;
    // flush_q counts those edges so a trigger held across reset is never
    // mistaken for a fresh low-to-high transition.
    if (flush_q == 2'd2) begin
      flush_d = flush_q;
    end else begin
      flush_d = flush_q + 2'd1;
    end
    armed_d     = armed_q | ((flush_q == 2'd2) & ~trig_s);
    trig_prev_d = trig_s;
    trig_rise_s = trig_s & ~trig_prev_q & armed_q;

    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    len_d   = len_q;
    echo_d  = 1'b0;
    short_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        if (trig_rise_s) begin
          state_d = ST_TRIG_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRIG_HI: begin
        // cnt_q excludes the rising-edge cycle seen in IDLE, hence the +1
        // inside count_reached.
        if (trig_s) begin
          cnt_d = sat_inc(cnt_q);
        end else if (count_reached(cnt_q, MIN_TRIG_CYC)) begin
          cnt_d   = 32'd0;
          state_d = ST_BURST;
          len_d   = clamp_len(echo_len, MAX_ECHO_CYC);
        end else begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (count_reached(cnt_q, BURST_CYC)) begin
          cnt_d   = 32'd0;
          state_d = ST_ECHO;
          echo_d  = 1'b1;
        end else begin
          echo_d  = 1'b0;
        end
      end
      ST_ECHO: begin
        if (count_reached(cnt_q, len_q)) begin
          cnt_d   = 32'd0;
          state_d = ST_HOLDOFF;
          done_d  = 1'b1;
        end else begin
          echo_d  = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (count_reached(cnt_q, HOLDOFF_CYC)) begin
          cnt_d   = 32'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLDOFF;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 32'd0;
      len_q       <= 32'd0;
      trig_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      flush_q     <= 2'd0;
      echo_q      <= 1'b0;
      busy_q      <= 1'b0;
      short_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      trig_prev_q <= trig_prev_d;
      armed_q     <= armed_d;
      flush_q     <= flush_d;
      echo_q      <= echo_d;
      busy_q      <= busy_d;
      short_q     <= short_d;
      done_q      <= done_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign short_trig = short_q;
  assign echo_done  = done_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Self-checking bench: timestamp-based reference model compared every
// cycle, plus hand-computed literal expectations per scenario.
module tb_ultrasonic_echo_responder;

  localparam longint T_MIN   = 10;
  localparam longint T_BURST = 20;
  localparam longint T_MAX   = 100;
  localparam longint T_HOLD  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] echo_len = 32'd0;
  logic        echo, busy, short_trig, echo_done;

  ultrasonic_echo_responder #(
    .MIN_TRIG_CYC (10),
    .BURST_CYC    (20),
    .MAX_ECHO_CYC (100),
    .HOLDOFF_CYC  (50)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger    (trigger),
    .echo_len   (echo_len),
    .echo       (echo),
    .busy       (busy),
    .short_trig (short_trig),
    .echo_done  (echo_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_int(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_bits(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  longint tb_cyc = 0;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // ---------------- reference model (timestamps of each phase) -------------
  logic   m_s1, m_s2, m_s1v, m_s2v, m_prev, m_armed, m_in_trig;
  longint m_cyc = 0;
  longint m_hi, m_idle_at, m_rise, m_fall, m_short_at;

  initial begin
    longint old_cyc;
    longint len;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_s1v = 1'b0; m_s2v = 1'b0;
        m_prev = 1'b0; m_armed = 1'b0; m_in_trig = 1'b0;
        m_hi = 0; m_idle_at = 0; m_rise = -1; m_fall = -1; m_short_at = -1;
      end else begin
        old_cyc = m_cyc;
        m_cyc   = m_cyc + 1;
        if (!m_in_trig) begin
          if (old_cyc >= m_idle_at && m_armed && m_s2 && !m_prev) begin
            m_in_trig = 1'b1;
            m_hi      = 1;
          end
        end else if (m_s2) begin
          m_hi = m_hi + 1;
        end else begin
          m_in_trig = 1'b0;
          if (m_hi >= T_MIN) begin
            if (echo_len == 32'd0) len = 1;
            else if (longint'(echo_len) > T_MAX) len = T_MAX;
            else len = longint'(echo_len);
            m_rise    = m_cyc + T_BURST;
            m_fall    = m_rise + len;
            m_idle_at = m_fall + T_HOLD;
          end else begin
            m_short_at = m_cyc;
          end
        end
        m_armed = m_armed | (m_s2v & ~m_s2);
        m_prev  = m_s2;
        m_s2    = m_s1;
        m_s2v   = m_s1v;
        m_s1    = trigger;
        m_s1v   = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare against the model --------------------
  initial begin
    logic [3:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_bits("reset_hold", {echo, busy, short_trig, echo_done}, 4'b0000);
      end else begin
        exp_v = {(m_cyc >= m_rise && m_cyc < m_fall),
                 (m_in_trig || m_cyc < m_idle_at),
                 (m_cyc == m_short_at),
                 (m_cyc == m_fall)};
        check_bits($sformatf("model_cyc%0d {echo,busy,short,done}", m_cyc),
                   {echo, busy, short_trig, echo_done}, exp_v);
      end
    end
  end

  // ---------------- monitor for literal expectations -----------------------
  longint widths[$];
  longint run = 0, rise_cyc = 0, fall_cyc = 0, busy_low_cyc = 0;
  int     n_short = 0, n_done = 0;
  logic   busy_was = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        busy_was = 1'b0;
      end else begin
        if (echo) begin
          if (run == 0) rise_cyc = tb_cyc;
          run = run + 1;
        end else if (run > 0) begin
          if (echo_done) begin
            widths.push_back(run);
            fall_cyc = tb_cyc;
          end
          run = 0;
        end
        if (short_trig) n_short++;
        if (echo_done) n_done++;
        if (busy_was && !busy) busy_low_cyc = tb_cyc;
        busy_was = busy;
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n, output longint f);
    trigger = 1'b1;
    wait_cyc(n);
    trigger = 1'b0;
    f = tb_cyc;
  endtask

  // ---------------- directed scenarios -------------------------------------
  initial begin
    longint f, f2;
    int nw, ns, nd;

    repeat (3) @(posedge clk);
    #1;
    check_bits("reset_outputs", {echo, busy, short_trig, echo_done}, 4'b0000);
    rst_n = 1'b1;
    wait_cyc(5);

    // Nominal measurement: 12-cycle trigger, width 40.
    echo_len = 32'd40;
    pulse(12, f);
    wait_cyc(140);
    check_int("nominal_count", widths.size(), 1);
    check_int("nominal_width", widths[$], 40);
    check_int("nominal_rise_delay", rise_cyc - f, 23);
    check_int("nominal_holdoff", busy_low_cyc - fall_cyc, 50);
    check_int("nominal_done", n_done, 1);
    check_int("nominal_no_short", n_short, 0);

    // Short trigger (5 cycles) and the 9/10 cycle boundary.
    pulse(5, f);
    wait_cyc(10);
    check_int("short5_pulse", n_short, 1);
    check_int("short5_no_echo", widths.size(), 1);
    check_int("short5_busy", longint'(busy), 0);
    pulse(9, f);
    wait_cyc(10);
    check_int("short9_pulse", n_short, 2);
    echo_len = 32'd7;
    pulse(10, f);
    wait_cyc(100);
    check_int("qual10_width", widths[$], 7);
    check_int("qual10_no_short", n_short, 2);

    // Clamping of the commanded width.
    echo_len = 32'd500;
    pulse(12, f);
    wait_cyc(200);
    check_int("clamp_max_width", widths[$], 100);
    echo_len = 32'd0;
    pulse(12, f);
    wait_cyc(100);
    check_int("zero_len_width", widths[$], 1);

    // Length change after latch and trigger activity while busy.
    nw = widths.size();
    ns = n_short;
    echo_len = 32'd40;
    pulse(12, f);
    wait_cyc(5);
    echo_len = 32'd70;
    wait_cyc(25);
    pulse(12, f2);
    wait_cyc(28);
    pulse(3, f2);
    wait_cyc(70);
    check_int("latched_count", widths.size(), nw + 1);
    check_int("latched_width", widths[$], 40);
    check_int("busy_trig_no_short", n_short, ns);

    // Reset at echo cycle 15 with trigger held high.
    nw = widths.size();
    nd = n_done;
    echo_len = 32'd60;
    pulse(12, f);
    wait_cyc(38);
    trigger = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_int("reset_echo_async", longint'(echo), 0);
    check_int("reset_busy_async", longint'(busy), 0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(30);
    check_int("reset_no_done", n_done, nd);
    check_int("reset_no_width", widths.size(), nw);
    check_int("reset_held_no_start", longint'(busy), 0);
    trigger = 1'b0;
    wait_cyc(3);
    echo_len = 32'd25;
    pulse(10, f);
    wait_cyc(120);
    check_int("after_reset_width", widths[$], 25);
    check_int("after_reset_count", widths.size(), nw + 1);

    // Back-to-back: second trigger one cycle after holdoff ends.
    echo_len = 32'd30;
    pulse(12, f);
    wait_cyc(5);
    echo_len = 32'd45;
    wait_cyc(99);
    pulse(12, f2);
    wait_cyc(140);
    check_int("b2b_first_width", widths[widths.size() - 2], 30);
    check_int("b2b_second_width", widths[$], 45);
    check_int("b2b_second_rise", rise_cyc - f2, 23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
